blink_led_core: RTL and testbench

Free-running LED pattern generator for board-level diagnostics. It divides the system clock down to a human-visible rate and drives one LED with one of four patterns: off, on, blink or heartbeat. It also emits a one-cycle tick per pattern period for other status logic. It sits beside the video pipeline on the pixel clock and feeds LED[0].

---
 rtl/blink_led_core.sv | 124 ++++++++++++
 tb/tb_blink_led_core.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_led_core.sv
// -----------------------------------------------------------------------------
// blink_led_core
//
// Free-running LED pattern generator for board-level diagnostics. The system
// clock is divided down to a human-visible period, and one LED is driven with
// one of four patterns: off, on, blink (duty-cycled) or heartbeat (two short
// pulses per period). A one-cycle tick is emitted once per period for other
// status logic.
//
// Parameters:
//   CLOCK_FREQ_HZ - input clock frequency in Hz
//   BLINK_HZ      - pattern repetition rate in Hz
//   DUTY_PCT      - on-time percentage in blink mode (0..100)
//
// Ports:
//   clk_i    in   1  sole clock, rising-edge
//   rst_i    in   1  asynchronous active-high reset
//   enable_i in   1  period counter advances while high
//   mode_i   in   2  0 = off, 1 = on, 2 = blink, 3 = heartbeat
//   led_o    out  1  registered LED drive
//   tick_o   out  1  registered one-cycle pulse, once per period
//
// Build option:
//   BLINK_LED_ACTIVE_LOW_EN - when defined, led_o carries the inverted pattern
//   and resets to 1 (LED wired to the supply). tick_o is unaffected.
// -----------------------------------------------------------------------------
module blink_led_core #(
    parameter int unsigned CLOCK_FREQ_HZ = 32'd50_000_000,
    parameter int unsigned BLINK_HZ      = 32'd1,
    parameter int unsigned DUTY_PCT      = 32'd50
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic [1:0] mode_i,
    output logic       led_o,
    output logic       tick_o
);

    localparam int unsigned PERIOD = CLOCK_FREQ_HZ / BLINK_HZ;
    // Width floor of 1 keeps the declarations legal while the period check
    // below reports the real problem.
    localparam int unsigned CNT_W  = (PERIOD < 32'd2) ? 32'd1 : $clog2(PERIOD);

    // Thresholds are kept 64 bits wide: ON_CYCLES may equal PERIOD, which does
    // not fit in the counter width.
    localparam logic [63:0] ON_CYCLES = (64'(PERIOD) * 64'(DUTY_PCT)) / 64'd100;
    localparam logic [63:0] HB        = 64'(PERIOD / 32'd8);
    localparam logic [63:0] HB_X2     = HB * 64'd2;
    localparam logic [63:0] HB_X3     = HB * 64'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 32'd1);

`ifdef BLINK_LED_ACTIVE_LOW_EN
    localparam logic LED_INV = 1'b1;
`else
    localparam logic LED_INV = 1'b0;
`endif

    generate
        if (PERIOD < 32'd2) begin : g_bad_period
            $error("blink_led_core: CLOCK_FREQ_HZ / BLINK_HZ must be at least 2");
        end
        if (DUTY_PCT > 32'd100) begin : g_bad_duty
            $error("blink_led_core: DUTY_PCT must be in 0..100");
        end
    endgenerate

    // Pattern value for a given mode at a given phase of the period.
    function automatic logic pattern_f(input logic [1:0] mode, input logic [63:0] cnt);
        logic result;
        case (mode)
            2'd0:    result = 1'b0;
            2'd1:    result = 1'b1;
            2'd2:    result = (cnt < ON_CYCLES);
            2'd3:    result = (cnt < HB) || ((cnt >= HB_X2) && (cnt < HB_X3));
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             led_q;
    logic             led_d;
    logic             tick_q;
    logic             tick_d;
    logic             at_last_s;

    // Next-state logic: period counter, LED pattern and period tick.
    always_comb begin
        cnt_d     = cnt_q;
        at_last_s = (cnt_q == CNT_LAST);
        if (enable_i) begin
            if (at_last_s) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
        // The LED is refreshed even while paused so mode changes still land.
        led_d  = pattern_f(mode_i, 64'(cnt_q)) ^ LED_INV;
        tick_d = enable_i & at_last_s;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= {CNT_W{1'b0}};
            led_q  <= LED_INV;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    assign led_o  = led_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_blink_led_core.sv
// -----------------------------------------------------------------------------
// tb_blink_led_core
//
// Directed bench for blink_led_core with PERIOD = 16, DUTY_PCT = 50
// (ON_CYCLES = 8, HB = 2). Outputs are sampled on the falling edge; inputs are
// changed there too. Expected LED values come from hand-written 16-bit phase
// masks (bit i = LED value produced from counter phase i).
// Honors BLINK_LED_ACTIVE_LOW_EN for the expected LED polarity.
// -----------------------------------------------------------------------------
module tb_blink_led_core;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [1:0] mode;
    logic       led;
    logic       tick;

    int checks;
    int errors;

`ifdef BLINK_LED_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic [15:0] blink_mask;
    logic [15:0] hb_mask;

    blink_led_core #(
        .CLOCK_FREQ_HZ(32'd16),
        .BLINK_HZ     (32'd1),
        .DUTY_PCT     (32'd50)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .enable_i(enable),
        .mode_i  (mode),
        .led_o   (led),
        .tick_o  (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        enable = 1'b1;
        mode   = 2'd2;
        step();
        step();
        checks++;
        if (led !== INV) begin
            errors++;
            $display("FAIL reset_led: got %b expected %b", led, INV);
        end
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick: got %b expected 0", tick);
        end
    endtask

    // Release into blink mode: two full periods, ticks on edges 16 and 32.
    task automatic test_blink();
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            logic exp_led;
            logic exp_tick;
            int   ph;
            step();
            ph       = (k - 1) % 16;
            exp_led  = blink_mask[ph] ^ INV;
            exp_tick = (ph == 15);
            checks++;
            if (led !== exp_led) begin
                errors++;
                $display("FAIL blink_led edge %0d: got %b expected %b", k, led, exp_led);
            end
            checks++;
            if (tick !== exp_tick) begin
                errors++;
                $display("FAIL blink_tick edge %0d: got %b expected %b", k, tick, exp_tick);
            end
        end
    endtask

    task automatic test_heartbeat();
        mode = 2'd3;
        for (int k = 1; k <= 16; k++) begin
            logic exp_led;
            logic exp_tick;
            step();
            exp_led  = hb_mask[k - 1] ^ INV;
            exp_tick = (k == 16);
            checks++;
            if (led !== exp_led) begin
                errors++;
                $display("FAIL hb_led edge %0d: got %b expected %b", k, led, exp_led);
            end
            checks++;
            if (tick !== exp_tick) begin
                errors++;
                $display("FAIL hb_tick edge %0d: got %b expected %b", k, tick, exp_tick);
            end
        end
    endtask

    // Pause at phase 5 for 20 cycles, then resume from phase 5.
    task automatic test_pause();
        mode = 2'd2;
        for (int k = 1; k <= 5; k++) begin
            step();
        end
        enable = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if (led !== (1'b1 ^ INV)) begin
                errors++;
                $display("FAIL pause_led cycle %0d: got %b expected %b", k, led, 1'b1 ^ INV);
            end
            checks++;
            if (tick !== 1'b0) begin
                errors++;
                $display("FAIL pause_tick cycle %0d: got %b expected 0", k, tick);
            end
        end
        enable = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            logic exp_led;
            logic exp_tick;
            step();
            exp_led  = blink_mask[4 + k] ^ INV;
            exp_tick = (k == 11);
            checks++;
            if (led !== exp_led) begin
                errors++;
                $display("FAIL resume_led edge %0d: got %b expected %b", k, led, exp_led);
            end
            checks++;
            if (tick !== exp_tick) begin
                errors++;
                $display("FAIL resume_tick edge %0d: got %b expected %b", k, tick, exp_tick);
            end
        end
    endtask

    // Enable dropped on the wrap cycle: no tick until enable returns.
    task automatic test_wrap_pause();
        for (int k = 1; k <= 15; k++) begin
            step();
        end
        enable = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (tick !== 1'b0) begin
                errors++;
                $display("FAIL wrap_hold_tick cycle %0d: got %b expected 0", k, tick);
            end
            checks++;
            if (led !== (1'b0 ^ INV)) begin
                errors++;
                $display("FAIL wrap_hold_led cycle %0d: got %b expected %b", k, led, 1'b0 ^ INV);
            end
        end
        enable = 1'b1;
        step();
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL wrap_resume_tick: got %b expected 1", tick);
        end
    endtask

    task automatic test_mode_switch();
        for (int k = 1; k <= 3; k++) begin
            step();
        end
        mode = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (led !== (1'b0 ^ INV)) begin
                errors++;
                $display("FAIL switch_off_led edge %0d: got %b expected %b", k, led, 1'b0 ^ INV);
            end
        end
        mode = 2'd1;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (led !== (1'b1 ^ INV)) begin
                errors++;
                $display("FAIL switch_on_led edge %0d: got %b expected %b", k, led, 1'b1 ^ INV);
            end
            checks++;
            if (tick !== (k == 10)) begin
                errors++;
                $display("FAIL switch_tick edge %0d: got %b expected %b", k, tick, (k == 10));
            end
        end
        // Mode changes still apply with the counter paused.
        enable = 1'b0;
        mode   = 2'd0;
        step();
        checks++;
        if (led !== (1'b0 ^ INV)) begin
            errors++;
            $display("FAIL paused_mode0_led: got %b expected %b", led, 1'b0 ^ INV);
        end
        mode = 2'd1;
        step();
        checks++;
        if (led !== (1'b1 ^ INV)) begin
            errors++;
            $display("FAIL paused_mode1_led: got %b expected %b", led, 1'b1 ^ INV);
        end
    endtask

    task automatic test_async_reset();
        enable = 1'b1;
        mode   = 2'd1;
        for (int k = 1; k <= 16; k++) begin
            step();
        end
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_tick: got %b expected 1", tick);
        end
        // Assert reset between edges and look before the next rising edge.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (led !== INV) begin
            errors++;
            $display("FAIL async_reset_led: got %b expected %b", led, INV);
        end
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_tick: got %b expected 0", tick);
        end
        @(negedge clk);
        step();
        mode = 2'd2;
        rst  = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            logic exp_led;
            step();
            exp_led = blink_mask[k - 1] ^ INV;
            checks++;
            if (led !== exp_led) begin
                errors++;
                $display("FAIL restart_led edge %0d: got %b expected %b", k, led, exp_led);
            end
            checks++;
            if (tick !== 1'b0) begin
                errors++;
                $display("FAIL restart_tick edge %0d: got %b expected 0", k, tick);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        blink_mask = 16'h00FF;
        hb_mask    = 16'h0033;
        rst        = 1'b1;
        enable     = 1'b0;
        mode       = 2'd0;

        test_reset();
        test_blink();
        test_heartbeat();
        test_pause();
        test_wrap_pause();
        test_mode_switch();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
